// File: rtl/mod_inverse.sv
// Iterative extended-Euclid unit: returns a^-1 mod m and gcd(a mod m, m),
// one quotient step per clock, valid/ready handshakes on both sides.
module mod_inverse #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] inverse,
    output logic [WIDTH-1:0] gcd,
    output logic             exists,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t state, state_next;

    logic        [WIDTH-1:0] r0, r1, m_latched;
    logic signed [WIDTH:0]   t0, t1;

    logic        [WIDTH-1:0]   q;
    logic        [2*WIDTH-1:0] qr_full;
    logic        [WIDTH-1:0]   r_next;
    logic signed [2*WIDTH+1:0] q_ext, t1_ext, qt_full;
    logic signed [WIDTH:0]     t_next;
    logic        [WIDTH-1:0]   a_red;
    logic signed [WIDTH:0]     t0_adj;
    logic                      fix_exists;
    logic        [WIDTH-1:0]   fix_inverse;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (in_valid)   state_next = ITER;
            ITER: if (r1 == '0)   state_next = FIX;
            FIX:                  state_next = DONE;
            DONE: if (out_ready)  state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // ---------------- output logic (state only, no path from in_valid/out_ready) ----------------
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // ---------------- step datapath ----------------
    always_comb begin
        q       = (r1 != '0) ? r0 / r1 : '0;
        qr_full = {{WIDTH{1'b0}}, q} * {{WIDTH{1'b0}}, r1};
        r_next  = r0 - qr_full[WIDTH-1:0];

        // |t| <= m keeps the truncated product exact in WIDTH+1 bits.
        q_ext   = $signed({{(WIDTH+2){1'b0}}, q});
        t1_ext  = $signed({{(WIDTH+1){t1[WIDTH]}}, t1});
        qt_full = q_ext * t1_ext;
        t_next  = t0 - $signed(qt_full[WIDTH:0]);

        a_red   = (m == '0) ? '0 : a % m;

        t0_adj      = t0 + $signed({1'b0, m_latched});
        fix_exists  = (r0 == WIDTH'(1)) && (m_latched >= WIDTH'(2));
        fix_inverse = t0[WIDTH] ? t0_adj[WIDTH-1:0] : t0[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r0        <= '0;
            r1        <= '0;
            t0        <= '0;
            t1        <= '0;
            m_latched <= '0;
            gcd       <= '0;
            inverse   <= '0;
            exists    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    r0        <= m;
                    r1        <= a_red;
                    t0        <= '0;
                    t1        <= (WIDTH+1)'(1);
                    m_latched <= m;
                end
                ITER: if (r1 != '0) begin
                    r0 <= r1;
                    r1 <= r_next;
                    t0 <= t1;
                    t1 <= t_next;
                end
                FIX: begin
                    gcd       <= r0;
                    exists    <= fix_exists;
                    inverse   <= fix_exists ? fix_inverse : '0;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_inverse.sv
// Self-checking bench for mod_inverse: scoreboard queue of expected results,
// fixed vectors, small random cases, backpressure and mid-run reset.
module tb_mod_inverse;

    localparam int WIDTH = 40;
    localparam logic [WIDTH-1:0] MAX_M = {WIDTH{1'b1}};

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, out_valid, out_ready, exists, busy;
    logic [WIDTH-1:0] a, m, inverse, gcd;

    typedef struct {
        logic [WIDTH-1:0] inv;
        logic [WIDTH-1:0] g;
        logic             ex;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mod_inverse #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .m(m), .out_valid(out_valid), .out_ready(out_ready),
        .inverse(inverse), .gcd(gcd), .exists(exists), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request and wait for acceptance; pushes the expectation when asked.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] mv,
                        input exp_t e, input bit push);
        @(negedge clk);
        check("in_ready_before_send", in_ready, 1'b1);
        a = av; m = mv; in_valid = 1'b1;
        @(posedge clk);
        if (push) sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    // Wait for out_valid, pop and compare, then complete the handshake.
    task automatic collect(input int hold);
        exp_t e;
        int   cycles = 0;
        logic [WIDTH-1:0] inv_s, gcd_s;
        logic ex_s;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!out_valid && cycles < 200);
        check("out_valid_timeout", out_valid, 1'b1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 1'b0, 1'b1);
        end else begin
            e = sb.pop_front();
            if (e.lat >= 0) check("latency", cycles, e.lat);
            check("inverse", inverse, e.inv);
            check("gcd", gcd, e.g);
            check("exists", exists, e.ex);
            inv_s = inverse; gcd_s = gcd; ex_s = exists;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = 1'b1; a = WIDTH'(i + 11); m = WIDTH'(97);
                @(posedge clk); #1;
                check("hold_out_valid", out_valid, 1'b1);
                check("hold_in_ready", in_ready, 1'b0);
                check("hold_inverse", inverse, inv_s);
                check("hold_gcd_exists", {gcd, exists}, {gcd_s, ex_s});
            end
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            check("out_valid_drop", out_valid, 1'b0);
            check("in_ready_return", in_ready, 1'b1);
            check("result_kept", inverse, inv_s);
            out_ready = 1'b0;
        end
    endtask

    function automatic exp_t model(input int unsigned av, input int unsigned mv);
        exp_t e;
        int unsigned x, y;
        e.lat = -1; e.inv = '0; e.ex = 1'b0;
        if (mv == 0) begin
            e.g = '0;
            return e;
        end
        x = av % mv; y = mv;
        if (x == 0) x = y;
        while (x != y) begin
            if (x > y) x = x - y; else y = y - x;
        end
        e.g = WIDTH'(x);
        if (x == 1 && mv >= 2) begin
            e.ex = 1'b1;
            for (int unsigned k = 1; k < mv; k++)
                if (((av % mv) * k) % mv == 1) e.inv = WIDTH'(k);
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] inv, input logic [WIDTH-1:0] g,
                                input logic ex, input int lat);
        exp_t e;
        e.inv = inv; e.g = g; e.ex = ex; e.lat = lat;
        return e;
    endfunction

    initial begin
        int unsigned ra, rm;
        exp_t dummy;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_results", {inverse, gcd, exists}, '0);
        @(negedge clk) reset = 1'b0;

        send(3, 7, mk(5, 1, 1'b1, 4), 1'b1);                      collect(0);
        send(17, 3120, mk(2753, 1, 1'b1, -1), 1'b1);              collect(0);
        send(10, 7, mk(5, 1, 1'b1, -1), 1'b1);                    collect(0);
        send(6, 9, mk(0, 3, 1'b0, -1), 1'b1);                     collect(0);
        send(0, 7, mk(0, 7, 1'b0, 2), 1'b1);                      collect(0);
        send(5, 1, mk(0, 1, 1'b0, -1), 1'b1);                     collect(0);
        send(5, 0, mk(0, 0, 1'b0, 2), 1'b1);                      collect(0);
        send(2, MAX_M, mk(WIDTH'(64'h80_0000_0000), 1, 1'b1, -1), 1'b1); collect(0);
        send(MAX_M - 1, MAX_M, mk(MAX_M - 1, 1, 1'b1, -1), 1'b1); collect(0);

        // Backpressure with ignored in_valid pulses
        send(17, 3120, mk(2753, 1, 1'b1, -1), 1'b1);              collect(10);

        for (int i = 0; i < 8; i++) begin
            rm = $urandom_range(150, 2);
            ra = $urandom_range(300, 0);
            send(WIDTH'(ra), WIDTH'(rm), model(ra, rm), 1'b1);
            collect(0);
        end

        // Reset mid-ITER aborts without a result
        dummy = mk(0, 0, 1'b0, -1);
        send(17, 3120, dummy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_outputs", {out_valid, inverse, gcd, exists}, '0);
        @(negedge clk) reset = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) check("abort_no_result", out_valid, 1'b0);
        end
        check("abort_idle", in_ready, 1'b1);
        send(3, 7, mk(5, 1, 1'b1, 4), 1'b1);                      collect(0);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
